eq_output_stage: RTL and testbench

- Downstream of the band-sum stage; consumes the summed 8-band sample with a valid/ready handshake.
- Applies master volume, then rounds and saturates to the DAC word width.
- Buffers samples in a small FIFO and serializes them to the DAC on a left-justified serial interface (bclk/lrclk/sdata).
- The mono sample is duplicated into the left and right slots.

---
 rtl/eq_output_stage_if.sv | 25 ++
 rtl/eq_output_stage.sv | 179 +++++++++++++++++
 tb/tb_eq_output_stage.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_output_stage_if.sv
// eq_output_stage_if: sample handshake between the band-sum stage
// and the output stage, with the master gain sampled on accept.
interface eq_output_stage_if #(
    parameter int SUM_BITS  = 19,
    parameter int GAIN_BITS = 8
);
    logic signed [SUM_BITS-1:0] sum_in;
    logic                       sum_valid;
    logic                       sum_ready;
    logic [GAIN_BITS-1:0]       master_gain;

    modport master (
        output sum_in,
        output sum_valid,
        output master_gain,
        input  sum_ready
    );

    modport slave (
        input  sum_in,
        input  sum_valid,
        input  master_gain,
        output sum_ready
    );
endinterface

// File: rtl/eq_output_stage.sv
// eq_output_stage: master volume, floor/saturate to DAC width, sample
// FIFO and left-justified serial output (mono duplicated into L/R).
module eq_output_stage #(
    parameter int SUM_BITS   = 19,
    parameter int OUT_BITS   = 16,
    parameter int GAIN_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_DIV   = 4
) (
    input  logic              clk,
    input  logic              rst,
    eq_output_stage_if.slave  up,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              clip_pulse,
    output logic              clip_sticky,
    output logic              underrun_sticky
);

    localparam int PW = SUM_BITS + GAIN_BITS + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(BCLK_DIV);
    localparam int FB = 2 * OUT_BITS;
    localparam int IW = $clog2(FB);

    logic                       s0_valid;
    logic signed [SUM_BITS-1:0] s0_sum;
    logic [GAIN_BITS-1:0]       s0_gain;
    logic                       s1_valid;
    logic signed [PW-1:0]       s1_prod;

    logic signed [PW-1:0]       a_ext;
    logic signed [PW-1:0]       g_ext;
    logic signed [PW-1:0]       prod_c;
    logic signed [PW-1:0]       shifted;
    logic [PW-OUT_BITS:0]       hi;
    logic                       sat_ovf;
    logic [OUT_BITS-1:0]        sat_word;

    logic [OUT_BITS-1:0]        mem [FIFO_DEPTH];
    logic [CW-1:0]              wr_ptr;
    logic [CW-1:0]              rd_ptr;
    logic [CW-1:0]              count;
    logic [CW:0]                occupancy;
    logic [OUT_BITS-1:0]        head;

    logic                       accept;
    logic                       push;
    logic                       pop;
    logic                       fall;
    logic                       wrap;

    logic [DW-1:0]              div;
    logic [IW-1:0]              bit_idx;
    logic [FB-1:0]              shreg;

    // Reserve a FIFO slot for every sample still in the pipeline.
    assign count     = wr_ptr - rd_ptr;
    assign occupancy = {1'b0, count}
                     + (CW+1)'(s0_valid)
                     + (CW+1)'(s1_valid);
    assign up.sum_ready = occupancy < (CW+1)'(FIFO_DEPTH);
    assign accept       = up.sum_valid && up.sum_ready;

    always_comb begin
        a_ext  = {{(PW-SUM_BITS){s0_sum[SUM_BITS-1]}}, s0_sum};
        g_ext  = {{(PW-GAIN_BITS){1'b0}}, s0_gain};
        prod_c = a_ext * g_ext;
    end

    // Floor shift; overflow when the bits above the sign are not uniform.
    always_comb begin
        shifted  = s1_prod >>> (GAIN_BITS - 1);
        hi       = shifted[PW-1:OUT_BITS-1];
        sat_ovf  = !((&hi) || !(|hi));
        sat_word = shifted[OUT_BITS-1:0];
        unique case (1'b1)
            !sat_ovf:
                sat_word = shifted[OUT_BITS-1:0];
            sat_ovf && shifted[PW-1]:
                sat_word = {1'b1, {(OUT_BITS-1){1'b0}}};
            sat_ovf && !shifted[PW-1]:
                sat_word = {1'b0, {(OUT_BITS-1){1'b1}}};
            default:
                sat_word = shifted[OUT_BITS-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid    <= 1'b0;
            s0_sum      <= '0;
            s0_gain     <= '0;
            s1_valid    <= 1'b0;
            s1_prod     <= '0;
            clip_pulse  <= 1'b0;
            clip_sticky <= 1'b0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_sum  <= up.sum_in;
                s0_gain <= up.master_gain;
            end
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_prod <= prod_c;
            end
            clip_pulse <= s1_valid && sat_ovf;
            if (s1_valid && sat_ovf) begin
                clip_sticky <= 1'b1;
            end
        end
    end

    assign push = s1_valid;
    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= sat_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A bclk falling edge is the terminal count while bclk is high.
    assign fall = bclk && (div == DW'(BCLK_DIV - 1));
    assign wrap = fall && (bit_idx == IW'(FB - 1));
    assign pop  = wrap && (count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div             <= '0;
            bclk            <= 1'b0;
            bit_idx         <= '0;
            shreg           <= '0;
            underrun_sticky <= 1'b0;
        end else begin
            if (div == DW'(BCLK_DIV - 1)) begin
                div  <= '0;
                bclk <= !bclk;
            end else begin
                div <= div + 1'b1;
            end
            if (fall) begin
                if (wrap) begin
                    bit_idx <= '0;
                    if (pop) begin
                        shreg <= {head, head};
                    end else begin
                        shreg           <= '0;
                        underrun_sticky <= 1'b1;
                    end
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                    shreg   <= {shreg[FB-2:0], 1'b0};
                end
            end
        end
    end

    assign sdata = shreg[FB-1];
    assign lrclk = bit_idx >= IW'(OUT_BITS);

endmodule

// File: tb/tb_eq_output_stage.sv
// tb_eq_output_stage: directed and random checks of the output stage
// against an arithmetic reference model and a serial frame monitor.
module tb_eq_output_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic bclk;
    logic lrclk;
    logic sdata;
    logic clip_pulse;
    logic clip_sticky;
    logic underrun_sticky;

    always #5 clk = ~clk;

    eq_output_stage_if #(.SUM_BITS(19), .GAIN_BITS(8)) bus ();

    eq_output_stage dut (
        .clk             (clk),
        .rst             (rst),
        .up              (bus),
        .bclk            (bclk),
        .lrclk           (lrclk),
        .sdata           (sdata),
        .clip_pulse      (clip_pulse),
        .clip_sticky     (clip_sticky),
        .underrun_sticky (underrun_sticky)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] rx_q[$];
    int          mbits;
    logic [31:0] msh;
    logic [31:0] mlr;

    // Frame monitor: sample sdata/lrclk on bclk rising edges.
    always @(posedge bclk or negedge rst) begin
        if (!rst) begin
            mbits <= 0;
            msh   <= '0;
            mlr   <= '0;
        end else if (mbits == 31) begin
            rx_q.push_back({mlr[30:0], lrclk, msh[30:0], sdata});
            mbits <= 0;
        end else begin
            msh   <= {msh[30:0], sdata};
            mlr   <= {mlr[30:0], lrclk};
            mbits <= mbits + 1;
        end
    end

    logic [15:0] exp_q[$];
    bit          exp_clip;
    int          acc;
    int          k;
    bit          have_cur;
    int          cur_s;
    int          cur_g;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint ref_q(input int s, input int g);
        longint p;
        longint q;
        p = longint'(s) * longint'(g);
        q = p / 128;
        if (p < 0 && (p % 128) != 0) q = q - 1;
        return q;
    endfunction

    function automatic bit ref_clip(input int s, input int g);
        longint q;
        q = ref_q(s, g);
        return (q > 32767) || (q < -32768);
    endfunction

    function automatic logic [15:0] ref_word(input int s, input int g);
        longint q;
        q = ref_q(s, g);
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return 16'(q);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.sum_valid = 1'b0;
        bus.sum_in = '0;
        bus.master_gain = 8'd128;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rx_q.delete();
        exp_q.delete();
        exp_clip = 1'b0;
        acc = 0;
        have_cur = 1'b0;
    endtask

    task automatic send(input int s, input int g);
        int n;
        @(negedge clk);
        bus.sum_in = 19'(s);
        bus.master_gain = 8'(g);
        bus.sum_valid = 1'b1;
        n = 0;
        while (!bus.sum_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(bus.sum_ready), 32'd1);
        @(negedge clk);
        bus.sum_valid = 1'b0;
    endtask

    task automatic get_frame(output logic [63:0] f);
        int n;
        n = 0;
        while (rx_q.size() == 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_arrived", 32'(rx_q.size() != 0), 32'd1);
        f = (rx_q.size() != 0) ? rx_q.pop_front() : 64'd0;
    endtask

    task automatic chk_frame(input string tag, input logic [15:0] w);
        logic [63:0] f;
        get_frame(f);
        chk({tag, "_left"}, 32'(f[31:16]), 32'(w));
        chk({tag, "_right"}, 32'(f[15:0]), 32'(w));
        chk({tag, "_lrclk"}, f[63:32], 32'h0000FFFF);
    endtask

    task automatic count_pulses(output int c);
        c = 0;
        repeat (6) begin
            @(negedge clk);
            if (clip_pulse) c++;
        end
    endtask

    task automatic bclk_period(output int p);
        int   t0;
        int   n;
        logic prev;
        t0 = -1;
        n = 0;
        p = 0;
        prev = bclk;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bclk && !prev) begin
                if (t0 < 0) begin
                    t0 = n;
                end else begin
                    p = n - t0;
                    break;
                end
            end
            prev = bclk;
        end
    endtask

    function automatic int rand_sum();
        logic signed [18:0] r;
        r = 19'($urandom);
        return int'(r);
    endfunction

    // Producer holding sum_valid high; a held sample stays until taken.
    task automatic stream(input int ncyc, input bit rnd);
        repeat (ncyc) begin
            @(negedge clk);
            if (!have_cur) begin
                cur_s = rnd ? rand_sum() : k;
                cur_g = rnd ? int'($urandom_range(0, 255)) : 128;
                have_cur = 1'b1;
            end
            bus.sum_in = 19'(cur_s);
            bus.master_gain = 8'(cur_g);
            bus.sum_valid = 1'b1;
            if (bus.sum_ready) begin
                exp_q.push_back(ref_word(cur_s, cur_g));
                exp_clip = exp_clip | ref_clip(cur_s, cur_g);
                acc++;
                k++;
                have_cur = 1'b0;
            end
        end
    endtask

    task automatic drain_check(input string tag);
        @(negedge clk);
        bus.sum_valid = 1'b0;
        chk_frame({tag, "_first"}, 16'h0000);
        foreach (exp_q[i]) begin
            chk_frame($sformatf("%s_data%0d", tag, i), exp_q[i]);
        end
        chk({tag, "_no_underrun"}, 32'(underrun_sticky), 32'd0);
    endtask

    initial begin
        int   p;
        int   c;
        int   a0;
        logic [63:0] f;

        bus.sum_valid = 1'b0;
        bus.sum_in = '0;
        bus.master_gain = 8'd128;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({bclk, lrclk, sdata, clip_pulse, clip_sticky, underrun_sticky}),
            32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.sum_ready), 32'd1);

        // Unity gain single sample, then an underrun frame.
        send(1000, 128);
        bclk_period(p);
        chk("bclk_period", 32'(p), 32'd8);
        chk_frame("t1_frame0", 16'h0000);
        chk("t1_underrun_f0", 32'(underrun_sticky), 32'd0);
        chk_frame("t1_frame1", 16'h03E8);
        chk("t1_underrun_f1", 32'(underrun_sticky), 32'd0);
        chk_frame("t5_idle", 16'h0000);
        chk("t5_underrun", 32'(underrun_sticky), 32'd1);

        // Saturation both ways.
        do_reset();
        send(100000, 128);
        count_pulses(c);
        chk("t2_pulse_pos", 32'(c), 32'd1);
        chk("t2_sticky", 32'(clip_sticky), 32'd1);
        send(-100000, 128);
        count_pulses(c);
        chk("t2_pulse_neg", 32'(c), 32'd1);
        chk_frame("t2_frame0", 16'h0000);
        chk_frame("t2_pos", 16'h7FFF);
        chk_frame("t2_neg", 16'h8000);

        // Floor rounding and zero gain.
        do_reset();
        send(-3, 64);
        count_pulses(c);
        chk("t3_pulse_a", 32'(c), 32'd0);
        send(-262144, 0);
        count_pulses(c);
        chk("t3_pulse_b", 32'(c), 32'd0);
        chk("t3_sticky", 32'(clip_sticky), 32'd0);
        chk_frame("t3_frame0", 16'h0000);
        chk_frame("t3_floor", 16'hFFFE);
        chk_frame("t3_gain0", 16'h0000);

        // Back-pressure with a counting producer.
        do_reset();
        k = 1;
        stream(8, 1'b0);
        chk("t4_fill_acc", 32'(acc), 32'd4);
        chk("t4_fill_ready", 32'(bus.sum_ready), 32'd0);
        stream(300, 1'b0);
        a0 = acc;
        stream(1024, 1'b0);
        chk("t4_rate", 32'(acc - a0), 32'd4);
        drain_check("t4");

        // Random values and gains, gain changing every sample.
        do_reset();
        stream(1300, 1'b1);
        drain_check("rnd");
        chk("rnd_clip_sticky", 32'(clip_sticky), 32'(exp_clip));

        // Reset in the middle of a frame with samples queued.
        do_reset();
        send(23130, 128);
        send(100000, 128);
        send(1, 128);
        send(2, 128);
        get_frame(f);
        chk("t6_frame0", 32'(f[31:0]), 32'd0);
        repeat (100) @(negedge clk);
        chk("t6_pre_sticky", 32'(clip_sticky), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_outputs",
            32'({bclk, lrclk, sdata, clip_pulse, clip_sticky, underrun_sticky}),
            32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rx_q.delete();
        chk("t6_ready", 32'(bus.sum_ready), 32'd1);
        chk_frame("t6_after0", 16'h0000);
        chk_frame("t6_after1", 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
